// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage: source select, load
// funct3 codes and the FSM state encoding.
package wb_pkg;

  typedef enum logic [1:0] {
    ALU  = 2'd0,
    LOAD = 2'd1,
    PC4  = 2'd2
  } wb_sel_e;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_LD = 1'b1
  } wb_state_e;

endpackage

// File: rtl/load_align.sv
// Load data alignment: extracts a byte/halfword from the response word at the
// latched offset and sign- or zero-extends it; everything else passes the word.
module load_align
  import wb_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statements can leave a latch behind.
  always_comb begin
    byte_sel = word[7:0];
    half_sel = word[15:0];
    data     = word;

    case (addr_lo)
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      2'd3:    byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase

    if (addr_lo[1]) half_sel = word[31:16];

    case (funct3)
      LB:      data = {{24{byte_sel[7]}}, byte_sel};
      LBU:     data = {24'h000000, byte_sel};
      LH:      data = {{16{half_sel[15]}}, half_sel};
      LHU:     data = {16'h0000, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB writeback stage: one-cycle register-file write for ALU/PC4 results,
// blocking wait for load responses. Optional retire counter under WB_INSTRET_EN.
module wb_stage
  import wb_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [4:0]  i_rd_addr,
  input  logic        i_rd_wren,
  input  logic [1:0]  i_wb_sel,
  input  logic [31:0] i_alu_data,
  input  logic [31:0] i_pc4,
  input  logic [2:0]  i_ld_funct3,
  input  logic [1:0]  i_ld_addr_lo,
  input  logic        i_lsu_rsp_valid,
  input  logic [31:0] i_lsu_rsp_data,
  output logic [4:0]  o_rd_addr,
  output logic [31:0] o_rd_data,
  output logic        o_rd_wren,
  output logic        o_pend_valid,
  output logic [4:0]  o_pend_rd,
  output logic        o_rsp_err,
  output logic [63:0] o_instret
);

  wb_state_e   state_q, state_d;
  logic        wr_en_q, wr_en_d;
  logic [4:0]  wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic [4:0]  ld_rd_q, ld_rd_d;
  logic        ld_wren_q, ld_wren_d;
  logic [2:0]  ld_funct3_q, ld_funct3_d;
  logic [1:0]  ld_addr_lo_q, ld_addr_lo_d;

  logic        accept;
  logic        is_load;
  logic [31:0] sel_data;
  logic [31:0] ld_data;

  load_align u_load_align (
    .funct3  (ld_funct3_q),
    .addr_lo (ld_addr_lo_q),
    .word    (i_lsu_rsp_data),
    .data    (ld_data)
  );

  assign o_ready  = (state_q == IDLE);
  assign accept   = i_valid & o_ready;
  assign is_load  = (i_wb_sel == LOAD);
  // Reserved select value 3 falls through to the ALU result.
  assign sel_data = (i_wb_sel == PC4) ? i_pc4 : i_alu_data;

  always_comb begin
    state_d      = state_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    rsp_err_d    = 1'b0;
    ld_rd_d      = ld_rd_q;
    ld_wren_d    = ld_wren_q;
    ld_funct3_d  = ld_funct3_q;
    ld_addr_lo_d = ld_addr_lo_q;

    case (state_q)
      IDLE: begin
        // A response with no load outstanding is dropped and flagged.
        rsp_err_d = i_lsu_rsp_valid;
        if (accept) begin
          if (is_load) begin
            state_d      = WAIT_LD;
            ld_rd_d      = i_rd_addr;
            ld_wren_d    = i_rd_wren;
            ld_funct3_d  = i_ld_funct3;
            ld_addr_lo_d = i_ld_addr_lo;
          end else begin
            wr_en_d = i_rd_wren & (i_rd_addr != 5'd0);
            if (wr_en_d) begin
              wr_addr_d = i_rd_addr;
              wr_data_d = sel_data;
            end
          end
        end
      end
      WAIT_LD: begin
        if (i_lsu_rsp_valid) begin
          state_d = IDLE;
          wr_en_d = ld_wren_q & (ld_rd_q != 5'd0);
          if (wr_en_d) begin
            wr_addr_d = ld_rd_q;
            wr_data_d = ld_data;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= 5'd0;
      wr_data_q    <= 32'd0;
      rsp_err_q    <= 1'b0;
      ld_rd_q      <= 5'd0;
      ld_wren_q    <= 1'b0;
      ld_funct3_q  <= 3'd0;
      ld_addr_lo_q <= 2'd0;
    end else begin
      state_q      <= state_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      rsp_err_q    <= rsp_err_d;
      ld_rd_q      <= ld_rd_d;
      ld_wren_q    <= ld_wren_d;
      ld_funct3_q  <= ld_funct3_d;
      ld_addr_lo_q <= ld_addr_lo_d;
    end
  end

  assign o_rd_wren    = wr_en_q;
  assign o_rd_addr    = wr_addr_q;
  assign o_rd_data    = wr_data_q;
  assign o_rsp_err    = rsp_err_q;
  assign o_pend_valid = (state_q == WAIT_LD) & ld_wren_q & (ld_rd_q != 5'd0);
  assign o_pend_rd    = (state_q == WAIT_LD) ? ld_rd_q : 5'd0;

`ifdef WB_INSTRET_EN
  logic [63:0] instret_q, instret_d;
  logic        slot_issue;

  // A write slot retires an instruction even when rd=0 suppresses the write.
  assign slot_issue = (accept & ~is_load) | ((state_q == WAIT_LD) & i_lsu_rsp_valid);

  always_comb begin
    instret_d = instret_q;
    if (slot_issue) instret_d = instret_q + 64'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) instret_q <= 64'd0;
    else          instret_q <= instret_d;
  end

  assign o_instret = instret_q;
`else
  assign o_instret = 64'd0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage; expected values are hand-derived.
// Retire-count expectations follow WB_INSTRET_EN when it is defined.
module tb_wb_stage;
  import wb_pkg::*;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [4:0]  i_rd_addr;
  logic        i_rd_wren;
  logic [1:0]  i_wb_sel;
  logic [31:0] i_alu_data;
  logic [31:0] i_pc4;
  logic [2:0]  i_ld_funct3;
  logic [1:0]  i_ld_addr_lo;
  logic        i_lsu_rsp_valid;
  logic [31:0] i_lsu_rsp_data;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd_data;
  logic        o_rd_wren;
  logic        o_pend_valid;
  logic [4:0]  o_pend_rd;
  logic        o_rsp_err;
  logic [63:0] o_instret;

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_instret = 64'd0;

  wb_stage dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_rd_addr      (i_rd_addr),
    .i_rd_wren      (i_rd_wren),
    .i_wb_sel       (i_wb_sel),
    .i_alu_data     (i_alu_data),
    .i_pc4          (i_pc4),
    .i_ld_funct3    (i_ld_funct3),
    .i_ld_addr_lo   (i_ld_addr_lo),
    .i_lsu_rsp_valid(i_lsu_rsp_valid),
    .i_lsu_rsp_data (i_lsu_rsp_data),
    .o_rd_addr      (o_rd_addr),
    .o_rd_data      (o_rd_data),
    .o_rd_wren      (o_rd_wren),
    .o_pend_valid   (o_pend_valid),
    .o_pend_rd      (o_pend_rd),
    .o_rsp_err      (o_rsp_err),
    .o_instret      (o_instret)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_instret(input string tag);
`ifdef WB_INSTRET_EN
    check(tag, o_instret, exp_instret);
`else
    check(tag, o_instret, 64'd0);
`endif
  endtask

  task automatic issue(input logic [1:0] sel, input logic [4:0] rd, input logic wren,
                       input logic [31:0] alu, input logic [31:0] pc4);
    i_valid    = 1'b1;
    i_wb_sel   = sel;
    i_rd_addr  = rd;
    i_rd_wren  = wren;
    i_alu_data = alu;
    i_pc4      = pc4;
  endtask

  // Accept a load, wait one cycle in WAIT_LD, then deliver the response.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [1:0] lo,
                         input logic [4:0] rd, input logic [31:0] rsp, input logic [31:0] exp);
    issue(2'd1, rd, 1'b1, 32'h0, 32'h0);
    i_ld_funct3  = f3;
    i_ld_addr_lo = lo;
    tick();
    i_valid = 1'b0;
    check({tag, "_ready"}, {63'd0, o_ready}, 64'd0);
    i_lsu_rsp_valid = 1'b1;
    i_lsu_rsp_data  = rsp;
    tick();
    i_lsu_rsp_valid = 1'b0;
    exp_instret++;
    check({tag, "_wren"}, {63'd0, o_rd_wren}, 64'd1);
    check({tag, "_addr"}, {59'd0, o_rd_addr}, {59'd0, rd});
    check({tag, "_data"}, {32'd0, o_rd_data}, {32'd0, exp});
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_rd_addr = 5'd0;
    i_rd_wren = 1'b0;
    i_wb_sel = 2'd0;
    i_alu_data = 32'h0;
    i_pc4 = 32'h0;
    i_ld_funct3 = 3'd0;
    i_ld_addr_lo = 2'd0;
    i_lsu_rsp_valid = 1'b0;
    i_lsu_rsp_data = 32'h0;

    #12;
    check("rst_ready", {63'd0, o_ready}, 64'd1);
    check("rst_wren", {63'd0, o_rd_wren}, 64'd0);
    check("rst_addr", {59'd0, o_rd_addr}, 64'd0);
    check("rst_data", {32'd0, o_rd_data}, 64'd0);
    check("rst_pend", {63'd0, o_pend_valid}, 64'd0);
    check("rst_pend_rd", {59'd0, o_pend_rd}, 64'd0);
    check("rst_err", {63'd0, o_rsp_err}, 64'd0);
    check("rst_instret", o_instret, 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick();

    // ALU write, then hold of addr/data when idle
    issue(2'd0, 5'd5, 1'b1, 32'h12345678, 32'h0);
    tick();
    i_valid = 1'b0;
    exp_instret++;
    check("alu_wren", {63'd0, o_rd_wren}, 64'd1);
    check("alu_addr", {59'd0, o_rd_addr}, 64'd5);
    check("alu_data", {32'd0, o_rd_data}, 64'h12345678);
    check_instret("alu_instret");
    tick();
    check("alu_wren_drop", {63'd0, o_rd_wren}, 64'd0);
    check("alu_hold_data", {32'd0, o_rd_data}, 64'h12345678);

    // Back-to-back PC4 then reserved select (treated as ALU)
    issue(2'd2, 5'd7, 1'b1, 32'hFFFF0000, 32'h00000200);
    tick();
    exp_instret++;
    check("b2b_ready", {63'd0, o_ready}, 64'd1);
    issue(2'd3, 5'd8, 1'b1, 32'h0000A5A5, 32'h00000044);
    check("b2b0_wren", {63'd0, o_rd_wren}, 64'd1);
    check("b2b0_addr", {59'd0, o_rd_addr}, 64'd7);
    check("b2b0_data", {32'd0, o_rd_data}, 64'h200);
    tick();
    i_valid = 1'b0;
    exp_instret++;
    check("b2b1_wren", {63'd0, o_rd_wren}, 64'd1);
    check("b2b1_addr", {59'd0, o_rd_addr}, 64'd8);
    check("b2b1_data", {32'd0, o_rd_data}, 64'h0000A5A5);
    check_instret("b2b_instret");
    tick();

    // LB at offset 3, response four cycles after accept
    issue(2'd1, 5'd10, 1'b1, 32'h0, 32'h0);
    i_ld_funct3  = LB;
    i_ld_addr_lo = 2'd3;
    tick();
    i_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("lb_wait%0d_ready", i), {63'd0, o_ready}, 64'd0);
      check($sformatf("lb_wait%0d_pend", i), {63'd0, o_pend_valid}, 64'd1);
      check($sformatf("lb_wait%0d_wren", i), {63'd0, o_rd_wren}, 64'd0);
      if (i < 3) tick();
    end
    check("lb_pend_rd", {59'd0, o_pend_rd}, 64'd10);
    i_lsu_rsp_valid = 1'b1;
    i_lsu_rsp_data  = 32'h80FFFFFF;
    tick();
    i_lsu_rsp_valid = 1'b0;
    exp_instret++;
    check("lb_wren", {63'd0, o_rd_wren}, 64'd1);
    check("lb_addr", {59'd0, o_rd_addr}, 64'd10);
    check("lb_data", {32'd0, o_rd_data}, 64'hFFFFFF80);
    check("lb_ready", {63'd0, o_ready}, 64'd1);
    check("lb_pend_clr", {63'd0, o_pend_valid}, 64'd0);
    check_instret("lb_instret");
    tick();

    // Remaining load types
    do_load("lhu", LHU, 2'd2, 5'd11, 32'hBEEF0000, 32'h0000BEEF);
    do_load("lh", LH, 2'd2, 5'd12, 32'hBEEF0000, 32'hFFFFBEEF);
    do_load("lh_lo", LH, 2'd0, 5'd13, 32'h00007FFE, 32'h00007FFE);
    do_load("lbu", LBU, 2'd1, 5'd14, 32'h11228033, 32'h00000080);
    do_load("lb0", LB, 2'd0, 5'd15, 32'h112280F3, 32'hFFFFFFF3);
    do_load("lw", LW, 2'd3, 5'd16, 32'hDEADBEEF, 32'hDEADBEEF);
    do_load("f3_111", 3'b111, 2'd1, 5'd17, 32'hCAFEF00D, 32'hCAFEF00D);
    check_instret("loads_instret");
    tick();

    // Load to x0: no pending flag, no write, still retires
    issue(2'd1, 5'd0, 1'b1, 32'h0, 32'h0);
    i_ld_funct3 = LW;
    tick();
    i_valid = 1'b0;
    check("ld_x0_pend", {63'd0, o_pend_valid}, 64'd0);
    check("ld_x0_ready", {63'd0, o_ready}, 64'd0);
    i_lsu_rsp_valid = 1'b1;
    i_lsu_rsp_data  = 32'h55555555;
    tick();
    i_lsu_rsp_valid = 1'b0;
    exp_instret++;
    check("ld_x0_wren", {63'd0, o_rd_wren}, 64'd0);
    check("ld_x0_data", {32'd0, o_rd_data}, 64'hCAFEF00D);
    check_instret("ld_x0_instret");
    tick();

    // PC4 to x0: no write, held data, retires
    issue(2'd2, 5'd0, 1'b1, 32'h0, 32'h00000104);
    tick();
    i_valid = 1'b0;
    exp_instret++;
    check("pc4_x0_wren", {63'd0, o_rd_wren}, 64'd0);
    check("pc4_x0_addr", {59'd0, o_rd_addr}, 64'd17);
    check("pc4_x0_data", {32'd0, o_rd_data}, 64'hCAFEF00D);
    check_instret("pc4_x0_instret");

    // ALU with wren=0: no write
    issue(2'd0, 5'd3, 1'b0, 32'h99999999, 32'h0);
    tick();
    i_valid = 1'b0;
    exp_instret++;
    check("nowren_wren", {63'd0, o_rd_wren}, 64'd0);
    check_instret("nowren_instret");

    // Response while idle
    i_lsu_rsp_valid = 1'b1;
    i_lsu_rsp_data  = 32'h12121212;
    tick();
    i_lsu_rsp_valid = 1'b0;
    check("idle_rsp_err", {63'd0, o_rsp_err}, 64'd1);
    check("idle_rsp_wren", {63'd0, o_rd_wren}, 64'd0);
    check("idle_rsp_ready", {63'd0, o_ready}, 64'd1);
    check("idle_rsp_data", {32'd0, o_rd_data}, 64'hCAFEF00D);
    check_instret("idle_rsp_instret");
    tick();
    check("idle_rsp_err_clr", {63'd0, o_rsp_err}, 64'd0);

    // Reset while waiting for a load
    issue(2'd1, 5'd20, 1'b1, 32'h0, 32'h0);
    i_ld_funct3 = LW;
    tick();
    i_valid = 1'b0;
    check("rwait_pend", {63'd0, o_pend_valid}, 64'd1);
    i_rst_n = 1'b0;
    #2;
    exp_instret = 64'd0;
    check("rwait_ready", {63'd0, o_ready}, 64'd1);
    check("rwait_pend_clr", {63'd0, o_pend_valid}, 64'd0);
    check("rwait_pend_rd", {59'd0, o_pend_rd}, 64'd0);
    check("rwait_data", {32'd0, o_rd_data}, 64'd0);
    check("rwait_instret", o_instret, 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_lsu_rsp_valid = 1'b1;
    i_lsu_rsp_data  = 32'h77777777;
    tick();
    i_lsu_rsp_valid = 1'b0;
    check("rwait_rsp_err", {63'd0, o_rsp_err}, 64'd1);
    check("rwait_rsp_wren", {63'd0, o_rd_wren}, 64'd0);
    check("rwait_rsp_addr", {59'd0, o_rd_addr}, 64'd0);
    check_instret("rwait_rsp_instret");
    tick();
    check("rwait_err_clr", {63'd0, o_rsp_err}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have i_clk input 1: rising-edge clock.
REQ-002 SHALL have i_rst_n input 1: reset, asynchronous, active-low.
REQ-003 SHALL have i_valid input 1: a MEM/WB instruction is offered.
REQ-004 SHALL have o_ready output 1: the offered instruction is accepted this cycle when i_valid=1.
REQ-005 SHALL have i_rd_addr input 5 and i_rd_wren input 1: destination register and write request.
REQ-006 SHALL have i_wb_sel input 2: writeback source select, with 0=ALU, 1=LOAD and 2=PC4 (3 is reserved and handled as ALU).
REQ-007 SHALL have i_alu_data input 32 and i_pc4 input 32: the ALU result and the link value.
REQ-008 SHALL have i_ld_funct3 input 3 and i_ld_addr_lo input 2: the load type and the low address bits.
REQ-009 SHALL have i_lsu_rsp_valid input 1 and i_lsu_rsp_data input 32: the load response word.
REQ-010 SHALL have o_rd_addr output 5, o_rd_data output 32 and o_rd_wren output 1: the register-file write port.
REQ-011 SHALL have o_pend_valid output 1 and o_pend_rd output 5: the outstanding-load destination, for the decode interlock.
REQ-012 SHALL have o_rsp_err output 1: a one-cycle pulse on an unexpected load response.
REQ-013 SHALL have o_instret output 64: the retired-instruction count.

Function
REQ-014 SHALL implement FSM states IDLE and WAIT_LD.
REQ-015 SHALL drive o_ready=1 in IDLE and o_ready=0 in WAIT_LD.
REQ-016 SHALL treat acceptance (i_valid & o_ready) with i_wb_sel!=LOAD as follows: stay in IDLE, and in the next cycle drive o_rd_wren=i_rd_wren & (i_rd_addr!=0) for exactly one cycle, with the selected data.
REQ-017 SHALL treat acceptance with i_wb_sel=LOAD as follows: go to WAIT_LD, latch rd, wren, funct3 and addr_lo, and keep o_rd_wren=0.
REQ-018 SHALL, in WAIT_LD with i_lsu_rsp_valid=1, return to IDLE and, in the next cycle, drive o_rd_wren for one cycle with the aligned load data.
REQ-019 SHALL hold WAIT_LD indefinitely while i_lsu_rsp_valid=0.
REQ-020 SHALL drive o_pend_valid=1 and o_pend_rd equal to the latched rd while in WAIT_LD, with o_pend_valid=0 when the latched rd=0 or wren=0.
REQ-021 SHALL, on i_lsu_rsp_valid=1 in IDLE, ignore the data, pulse o_rsp_err in the next cycle, and leave the FSM unchanged.
REQ-022 SHALL align load data from byte offset addr_lo for LB (000) with sign extension and LBU (100) with zero extension.
REQ-023 SHALL align load data from halfword addr_lo[1] for LH (001) with sign extension and LHU (101) with zero extension.
REQ-024 SHALL take LW (010) and all other funct3 values as the full word, ignoring addr_lo.
REQ-025 SHALL register o_rd_addr and o_rd_data, which hold their last values while o_rd_wren=0.
REQ-026 SHALL have a latency of 1 cycle from acceptance to write for ALU/PC4, and 1 cycle from response to write for LOAD.
REQ-027 SHALL allow an ALU/PC4 write and a new acceptance in the same cycle, giving back-to-back writes on consecutive cycles.

Reset
REQ-028 SHALL, on i_rst_n=0, immediately set the following values:
- state to IDLE;
- o_rd_wren, o_rd_addr, o_rd_data, o_pend_valid, o_pend_rd and o_rsp_err to 0;
- o_instret to 0.
REQ-029 SHALL abandon a reset asserted in WAIT_LD without performing the write.
REQ-030 SHALL ignore a response arriving in the first cycle after reset, and flag it through o_rsp_err.

Configuration
REQ-031 SHALL, when macro WB_INSTRET_EN is defined, make o_instret a 64-bit counter.
- It increments in the cycle a write slot issues, i.e. REQ-016 or REQ-018.
- It increments even when o_rd_wren=0 because rd=0 or wren=0.
- It wraps at 2^64.
REQ-032 SHALL, when WB_INSTRET_EN is undefined, keep the o_instret port but tie it to 0, with no counter logic.

Structure
REQ-033 SHALL place the wb_sel_e enum (ALU, LOAD, PC4), the load funct3 localparams (LB, LH, LW, LBU, LHU) and the FSM state enum in package wb_pkg.
REQ-034 SHALL implement alignment and extension in a combinational sub-module load_align, with inputs funct3, addr_lo and word, and output data.

Verification
REQ-035 SHALL cover: ALU accept, rd=5, alu=0x12345678 -> next cycle o_rd_wren=1, o_rd_addr=5, o_rd_data=0x12345678.
REQ-036 SHALL cover: LB, addr_lo=3, rsp=0x80FFFFFF sent 4 cycles after accept -> o_ready=0 and o_pend_valid=1 for 4 cycles, then o_rd_data=0xFFFFFF80.
REQ-037 SHALL cover: LHU, addr_lo=2, rsp=0xBEEF0000 -> 0x0000BEEF; LH on the same response -> 0xFFFFBEEF.
REQ-038 SHALL cover: PC4 with rd=0, pc4=0x104 -> o_rd_wren stays 0; with WB_INSTRET_EN defined, o_instret increments by 1.
REQ-039 SHALL cover: a response while IDLE -> o_rsp_err pulses 1 cycle and there is no write.
REQ-040 SHALL cover: reset pulse in WAIT_LD -> state IDLE, o_pend_valid=0, and a later response flags o_rsp_err.
